// File: rtl/fa25_arbiter.sv
// Two-port round-robin arbiter sharing one 25-bit ripple-carry adder.
// Grants at most one add/subtract per cycle into a single back-pressured response register.

module fa25_arbiter_adder (
  input  logic [24:0] a,
  input  logic [24:0] b,
  input  logic        cin,
  output logic [24:0] s,
  output logic        cout
);
  logic [25:0] carry_s;

  assign carry_s[0] = cin;

  for (genvar i = 0; i < 25; i++) begin : g_fa
    assign s[i]           = a[i] ^ b[i] ^ carry_s[i];
    assign carry_s[i + 1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
  end

  assign cout = carry_s[25];
endmodule

module fa25_arbiter #(
  parameter int DATA_WIDTH = 25
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic                  req0_cin,
  input  logic                  req0_sub,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  logic                  req1_cin,
  input  logic                  req1_sub,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_s,
  output logic                  rsp_cout,
  output logic                  rsp_id
);
  logic                  last_grant_r;
  logic                  winner_s;
  logic                  slot_free_s;
  logic                  grant_s;
  logic [DATA_WIDTH-1:0] a_s;
  logic [DATA_WIDTH-1:0] b_s;
  logic                  cin_s;
  logic                  sub_s;
  logic [DATA_WIDTH-1:0] b_eff_s;
  logic                  cin_eff_s;
  logic [DATA_WIDTH-1:0] sum_s;
  logic                  cout_s;

  // Round-robin pick: on contention the requester not served last wins.
  always_comb begin
    winner_s = 1'b0;
    if (req0_valid && req1_valid) begin
      winner_s = ~last_grant_r;
    end else if (req1_valid) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
  end

  assign slot_free_s = ~rsp_valid | rsp_ready;
  assign grant_s     = slot_free_s & (req0_valid | req1_valid);
  assign req0_ready  = grant_s & ~winner_s;
  assign req1_ready  = grant_s & winner_s;

  // Select the winner's operands and turn subtract into a + ~b + 1.
  always_comb begin
    a_s   = req0_a;
    b_s   = req0_b;
    cin_s = req0_cin;
    sub_s = req0_sub;
    if (winner_s) begin
      a_s   = req1_a;
      b_s   = req1_b;
      cin_s = req1_cin;
      sub_s = req1_sub;
    end else begin
      a_s   = req0_a;
      b_s   = req0_b;
      cin_s = req0_cin;
      sub_s = req0_sub;
    end
    b_eff_s   = sub_s ? ~b_s : b_s;
    cin_eff_s = sub_s ? 1'b1 : cin_s;
  end

  fa25_arbiter_adder u_adder (
    .a    (a_s),
    .b    (b_eff_s),
    .cin  (cin_eff_s),
    .s    (sum_s),
    .cout (cout_s)
  );

  // Response register and round-robin pointer; a drain and a new grant may coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid    <= 1'b0;
      rsp_s        <= {DATA_WIDTH{1'b0}};
      rsp_cout     <= 1'b0;
      rsp_id       <= 1'b0;
      last_grant_r <= 1'b1;
    end else if (grant_s) begin
      rsp_valid    <= 1'b1;
      rsp_s        <= sum_s;
      rsp_cout     <= cout_s;
      rsp_id       <= winner_s;
      last_grant_r <= winner_s;
    end else if (rsp_ready) begin
      rsp_valid    <= 1'b0;
    end else begin
      rsp_valid    <= rsp_valid;
    end
  end
endmodule

// File: tb/tb_fa25_arbiter.sv
// Scoreboard bench for fa25_arbiter: a reference model predicts grants and results,
// expected responses are queued at handshake and compared once the DUT registers them.

module tb_fa25_arbiter;
  localparam int W = 25;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_cin, req0_sub;
  logic         req1_valid, req1_cin, req1_sub;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ready, req1_ready;
  logic         rsp_valid, rsp_ready, rsp_cout, rsp_id;
  logic [W-1:0] rsp_s;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [26:0]  sb_q[$];
  logic         m_valid, m_cout, m_id, m_last;
  logic [W-1:0] m_s;
  logic         last_hs;
  int           mode;
  logic [3:0]   id_hist;

  always #5 clk = ~clk;

  fa25_arbiter #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req0_sub   (req0_sub),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .req1_sub   (req1_sub),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_s      (rsp_s),
    .rsp_cout   (rsp_cout),
    .rsp_id     (rsp_id)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns {cout, sum}; subtract carry means "no borrow", i.e. a >= b.
  function automatic logic [25:0] model_calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic cin, input logic sub);
    logic [25:0] r;
    if (sub) begin
      r[24:0] = a - b;
      r[25]   = (a >= b);
    end else begin
      r = {1'b0, a} + {1'b0, b} + {25'd0, cin};
    end
    return r;
  endfunction

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 3))
      0:       v = {W{1'b0}};
      1:       v = {W{1'b1}};
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  task automatic new_op(output logic [W-1:0] a, output logic [W-1:0] b,
                        output logic cin, output logic sub);
    a   = pick_operand();
    b   = pick_operand();
    cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
  endtask

  // One clock: predict grant, check readies, queue expectation, then check the response register.
  task automatic step();
    logic v0, v1, slot, w, hs;
    logic [26:0] e;
    @(negedge clk);
    v0   = req0_valid;
    v1   = req1_valid;
    slot = !m_valid || rsp_ready;
    if (v0 && v1) w = ~m_last;
    else if (v1)  w = 1'b1;
    else          w = 1'b0;
    hs = slot && (v0 || v1);
    check_eq("req0_ready", req0_ready, hs && !w);
    check_eq("req1_ready", req1_ready, hs && w);
    if (hs) begin
      if (w) sb_q.push_back({1'b1, model_calc(req1_a, req1_b, req1_cin, req1_sub)});
      else   sb_q.push_back({1'b0, model_calc(req0_a, req0_b, req0_cin, req0_sub)});
    end
    @(posedge clk);
    #1;
    if (hs) begin
      e       = sb_q.pop_front();
      m_valid = 1'b1;
      m_id    = e[26];
      m_cout  = e[25];
      m_s     = e[24:0];
      m_last  = w;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    check_eq("rsp_valid", rsp_valid, m_valid);
    check_eq("rsp_s", rsp_s, m_s);
    check_eq("rsp_cout", rsp_cout, m_cout);
    check_eq("rsp_id", rsp_id, m_id);
    last_hs = hs;
    if (mode == 1) begin
      if (hs && !w) new_op(req0_a, req0_b, req0_cin, req0_sub);
      if (hs && w)  new_op(req1_a, req1_b, req1_cin, req1_sub);
    end else if (mode == 0) begin
      if (hs && !w) req0_valid = 1'b0;
      if (hs && w)  req1_valid = 1'b0;
    end else begin
      if (!req0_valid || (hs && !w)) begin
        req0_valid = 1'($urandom_range(0, 1));
        new_op(req0_a, req0_b, req0_cin, req0_sub);
      end
      if (!req1_valid || (hs && w)) begin
        req1_valid = 1'($urandom_range(0, 1));
        new_op(req1_a, req1_b, req1_cin, req1_sub);
      end
    end
  endtask

  task automatic drain();
    mode = 0;
    for (int i = 0; i < 6; i++) begin
      if (req0_valid || req1_valid) step();
    end
    check_eq("drain_done", {req0_valid, req1_valid}, 2'b00);
  endtask

  task automatic set_req(input logic n, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub);
    if (n) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin; req1_sub = sub;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin; req0_sub = sub;
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_valid = 1'b0; m_s = {W{1'b0}}; m_cout = 1'b0; m_id = 1'b0; m_last = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0; req0_sub = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0; req1_sub = 1'b0;
    rsp_ready  = 1'b1;
    mode       = 0;
    last_hs    = 1'b0;
    id_hist    = 4'd0;
    model_reset();
    #2;
    check_eq("reset_rsp_valid", rsp_valid, 1'b0);
    check_eq("reset_rsp_s", rsp_s, 25'd0);
    check_eq("reset_ready_idle", {req0_ready, req1_ready}, 2'b00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    set_req(1'b0, 25'd10, 25'd3, 1'b0, 1'b1);
    step();
    check_eq("sub_10_3_s", rsp_s, 25'd7);
    check_eq("sub_10_3_cout", rsp_cout, 1'b1);
    check_eq("sub_10_3_id", rsp_id, 1'b0);

    set_req(1'b1, 25'd3, 25'd10, 1'b0, 1'b1);
    step();
    check_eq("sub_3_10_s", rsp_s, 25'h1FFFFF9);
    check_eq("sub_3_10_cout", rsp_cout, 1'b0);
    check_eq("sub_3_10_id", rsp_id, 1'b1);

    set_req(1'b1, 25'h1FFFFFF, 25'd1, 1'b0, 1'b0);
    step();
    check_eq("wrap_s", rsp_s, 25'd0);
    check_eq("wrap_cout", rsp_cout, 1'b1);

    // Continuous contention with rsp_ready high: expect 0,1,0,1 with no bubble.
    mode = 1;
    new_op(req0_a, req0_b, req0_cin, req0_sub);
    new_op(req1_a, req1_b, req1_cin, req1_sub);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      id_hist[i] = rsp_id;
      check_eq("stream_no_bubble", last_hs, 1'b1);
    end
    check_eq("alternation", id_hist, 4'b1010);

    rsp_ready = 1'b0;
    repeat (3) step();
    rsp_ready = 1'b1;
    step();
    check_eq("unfreeze_grant", last_hs, 1'b1);
    drain();

    set_req(1'b0, 25'h0000FF, 25'h000001, 1'b1, 1'b0);
    step();
    check_eq("add_cin_s", rsp_s, 25'h000101);
    check_eq("add_cin_cout", rsp_cout, 1'b0);
    set_req(1'b0, 25'h20, 25'h5, 1'b1, 1'b1);
    step();
    check_eq("sub_cin1_s", rsp_s, 25'h1B);
    set_req(1'b0, 25'h20, 25'h5, 1'b0, 1'b1);
    step();
    check_eq("sub_cin0_s", rsp_s, 25'h1B);

    mode = 2;
    for (int i = 0; i < 300; i++) begin
      rsp_ready = 1'($urandom_range(0, 3) != 0);
      step();
    end
    rsp_ready = 1'b1;
    drain();

    // Asynchronous reset while a result is held.
    rsp_ready = 1'b0;
    set_req(1'b1, 25'd5, 25'd6, 1'b0, 1'b0);
    step();
    check_eq("held_before_rst", rsp_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", rsp_valid, 1'b0);
    check_eq("async_rst_s", rsp_s, 25'd0);
    check_eq("async_rst_cout", rsp_cout, 1'b0);
    check_eq("async_rst_id", rsp_id, 1'b0);
    model_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    rst_n      = 1'b1;
    set_req(1'b0, 25'd100, 25'd1, 1'b0, 1'b0);
    set_req(1'b1, 25'd200, 25'd2, 1'b0, 1'b0);
    step();
    check_eq("post_rst_winner", rsp_id, 1'b0);
    check_eq("post_rst_s", rsp_s, 25'd101);
    step();
    check_eq("post_rst_second", rsp_id, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
